// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle MIPS sequencing controller; decodes IR fields and
//             drives datapath enables/selects, plus a retired-insn counter.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_wr,
   output logic             ir_wr,
   output logic             reg_wr,
   output logic             mem_wr,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       pc_src,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] c_FETCH   = 4'd0;
   localparam logic [3:0] c_DECODE  = 4'd1;
   localparam logic [3:0] c_EXE_R   = 4'd2;
   localparam logic [3:0] c_R_WB    = 4'd3;
   localparam logic [3:0] c_EXE_I   = 4'd4;
   localparam logic [3:0] c_I_WB    = 4'd5;
   localparam logic [3:0] c_MEM_ADR = 4'd6;
   localparam logic [3:0] c_MEM_RD  = 4'd7;
   localparam logic [3:0] c_MEM_WB  = 4'd8;
   localparam logic [3:0] c_MEM_WR  = 4'd9;
   localparam logic [3:0] c_BRANCH  = 4'd10;
   localparam logic [3:0] c_JUMP    = 4'd11;
   localparam logic [3:0] c_JAL     = 4'd12;
   localparam logic [3:0] c_JR      = 4'd13;

   localparam logic [3:0] c_I_NOP  = 4'd0;
   localparam logic [3:0] c_I_ADDU = 4'd1;
   localparam logic [3:0] c_I_SUBU = 4'd2;
   localparam logic [3:0] c_I_JR   = 4'd3;
   localparam logic [3:0] c_I_ORI  = 4'd4;
   localparam logic [3:0] c_I_LUI  = 4'd5;
   localparam logic [3:0] c_I_LW   = 4'd6;
   localparam logic [3:0] c_I_SW   = 4'd7;
   localparam logic [3:0] c_I_BEQ  = 4'd8;
   localparam logic [3:0] c_I_J    = 4'd9;
   localparam logic [3:0] c_I_JAL  = 4'd10;

   localparam logic [1:0] c_ALU_ADD = 2'd0;
   localparam logic [1:0] c_ALU_SUB = 2'd1;
   localparam logic [1:0] c_ALU_OR  = 2'd2;
   localparam logic [1:0] c_ALU_LUI = 2'd3;

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic [3:0]       w_cls;
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;
   logic             w_pc_wr, w_ir_wr, w_reg_wr, w_mem_wr;

   always_comb begin
      w_cls = c_I_NOP;
      case (op)
         6'h00: begin
            case (funct)
               6'h21:   w_cls = c_I_ADDU;
               6'h23:   w_cls = c_I_SUBU;
               6'h08:   w_cls = c_I_JR;
               default: w_cls = c_I_NOP;
            endcase
         end
         6'h0D:   w_cls = c_I_ORI;
         6'h0F:   w_cls = c_I_LUI;
         6'h23:   w_cls = c_I_LW;
         6'h2B:   w_cls = c_I_SW;
         6'h04:   w_cls = c_I_BEQ;
         6'h02:   w_cls = c_I_J;
         6'h03:   w_cls = c_I_JAL;
         default: w_cls = c_I_NOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire)
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Illegal codes 14-15 fall through to FETCH via the default arm.
   always_comb begin
      w_next = c_FETCH;
      case (r_state)
         c_FETCH: w_next = c_DECODE;
         c_DECODE: begin
            case (w_cls)
               c_I_ADDU, c_I_SUBU: w_next = c_EXE_R;
               c_I_ORI, c_I_LUI:   w_next = c_EXE_I;
               c_I_LW, c_I_SW:     w_next = c_MEM_ADR;
               c_I_BEQ:            w_next = c_BRANCH;
               c_I_J:              w_next = c_JUMP;
               c_I_JAL:            w_next = c_JAL;
               c_I_JR:             w_next = c_JR;
               default:            w_next = c_FETCH;
            endcase
         end
         c_EXE_R:   w_next = c_R_WB;
         c_EXE_I:   w_next = c_I_WB;
         c_MEM_ADR: w_next = (w_cls == c_I_LW) ? c_MEM_RD : c_MEM_WR;
         c_MEM_RD:  w_next = c_MEM_WB;
         default:   w_next = c_FETCH;
      endcase
   end

   always_comb begin
      w_pc_wr    = 1'b0;
      w_ir_wr    = 1'b0;
      w_reg_wr   = 1'b0;
      w_mem_wr   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = c_ALU_ADD;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      pc_src     = 2'd0;
      w_retire   = 1'b0;
      case (r_state)
         c_FETCH: begin
            w_ir_wr   = 1'b1;
            w_pc_wr   = 1'b1;
            alu_src_b = 2'd1;
         end
         c_DECODE: w_retire = (w_cls == c_I_NOP);
         c_EXE_R: begin
            alu_src_a = 1'b1;
            alu_op    = (w_cls == c_I_SUBU) ? c_ALU_SUB : c_ALU_ADD;
         end
         c_R_WB: begin
            w_reg_wr = 1'b1;
            reg_dst  = 2'd1;
            w_retire = 1'b1;
         end
         c_EXE_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd3;
            alu_op    = (w_cls == c_I_LUI) ? c_ALU_LUI : c_ALU_OR;
         end
         c_I_WB: begin
            w_reg_wr = 1'b1;
            w_retire = 1'b1;
         end
         c_MEM_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         c_MEM_WB: begin
            w_reg_wr   = 1'b1;
            mem_to_reg = 2'd1;
            w_retire   = 1'b1;
         end
         c_MEM_WR: begin
            w_mem_wr = 1'b1;
            w_retire = 1'b1;
         end
         c_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = c_ALU_SUB;
            pc_src    = 2'd1;
            w_pc_wr   = zero;
            w_retire  = 1'b1;
         end
         c_JUMP: begin
            w_pc_wr  = 1'b1;
            pc_src   = 2'd2;
            w_retire = 1'b1;
         end
         c_JAL: begin
            w_pc_wr    = 1'b1;
            pc_src     = 2'd2;
            w_reg_wr   = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            w_retire   = 1'b1;
         end
         c_JR: begin
            w_pc_wr  = 1'b1;
            pc_src   = 2'd3;
            w_retire = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset masks every write so an aborted instruction leaves no side effect.
   assign pc_wr   = w_pc_wr  & ~reset;
   assign ir_wr   = w_ir_wr  & ~reset;
   assign reg_wr  = w_reg_wr & ~reset;
   assign mem_wr  = w_mem_wr & ~reset;
   assign state   = r_state;
   assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It decodes the instruction register fields, steps each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. A retired-instruction counter is included for bench checking. It sits beside the shared ALU/memory datapath inside `mips`, driven by the same `clk` and `reset` as the CPU top.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk` input 1 system clock, rising edge
- `reset` input 1 synchronous, active-high reset
- `op` input 6 IR[31:26]
- `funct` input 6 IR[5:0]
- `zero` input 1 ALU zero flag (valid in BRANCH state)
- `pc_wr` output 1 PC write enable
- `ir_wr` output 1 instruction register write enable
- `reg_wr` output 1 register file write enable
- `mem_wr` output 1 data memory write enable
- `alu_src_a` output 1 0=PC, 1=rs
- `alu_src_b` output 2 0=rt, 1=const 4, 2=sign-ext imm, 3=zero-ext imm
- `alu_op` output 2 0=ADD, 1=SUB, 2=OR, 3=LUI (imm<<16)
- `reg_dst` output 2 0=rt, 1=rd, 2=$31
- `mem_to_reg` output 2 0=ALU out, 1=mem data, 2=PC
- `pc_src` output 2 0=ALU (PC+4), 1=branch target, 2={PC[31:28],idx,2'b00}, 3=rs
- `state` output 4 current state code (debug)
- `retired` output CNT_W instructions completed since reset

## Operation
- Decoded set: addu (0/21h), subu (0/23h), jr (0/08h), ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, j 02h, jal 03h. Any other op/funct = NOP.
- States: FETCH 0, DECODE 1, EXE_R 2, R_WB 3, EXE_I 4, I_WB 5, MEM_ADR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, JAL 12, JR 13. Codes 14–15 are illegal and go to FETCH.
- FETCH: `ir_wr`=1, `pc_wr`=1, `alu_src_a`=0, `alu_src_b`=1, ADD, `pc_src`=0. Go to DECODE.
- DECODE: no enables asserted. Next state by instruction: addu/subu→EXE_R; ori/lui→EXE_I; lw/sw→MEM_ADR; beq→BRANCH; j→JUMP; jal→JAL; jr→JR; NOP→FETCH.
- EXE_R: src_a=1, src_b=0, ADD for addu, SUB for subu. Go to R_WB.
- R_WB: `reg_wr`=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- EXE_I: src_a=1, src_b=3, OR for ori, LUI for lui. Go to I_WB.
- I_WB: `reg_wr`=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- MEM_ADR: src_a=1, src_b=2, ADD. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: no enables asserted. Go to MEM_WB.
- MEM_WB: `reg_wr`=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR: `mem_wr`=1. Go to FETCH.
- BRANCH: src_a=1, src_b=0, SUB, pc_src=1, `pc_wr`=`zero` (Mealy). Go to FETCH.
- JUMP: `pc_wr`=1, pc_src=2. Go to FETCH.
- JAL: `pc_wr`=1, pc_src=2, `reg_wr`=1, reg_dst=2, mem_to_reg=2. PC already holds PC+4 from FETCH. Go to FETCH.
- JR: `pc_wr`=1, pc_src=3. Go to FETCH.
- Defaults in every state unless listed above: all enables 0, all selects 0, ADD.
- `retired` increments by 1 on the final state of every instruction, NOP DECODE included. Wraps modulo 2^CNT_W.

## Timing
- Reset: on a clk edge with `reset`=1, `state`←FETCH and `retired`←0. While `reset`=1, `pc_wr`, `ir_wr`, `reg_wr` and `mem_wr` are forced to 0. The first fetch write occurs on the first edge after `reset` falls.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted in that cycle.
- Cycles per instruction: addu/subu/ori/lui/sw = 4; lw = 5; beq/j/jal/jr = 3; NOP = 2.
- All outputs are combinational from `state` (plus `op`, `funct`, `zero`). `op` and `funct` must be stable from DECODE until the instruction ends, since IR is written only in FETCH.
- beq not taken: `pc_wr`=0 in BRANCH, and PC keeps PC+4.

## Test plan
- Reset held 3 cycles, then released → `state`=0 and `retired`=0 during reset with all enables 0; `ir_wr`=`pc_wr`=1 in the cycle after release.
- Sequence ori, addu, lw, sw, lui (op/funct driven per state) → state traces 0,1,4,5 / 0,1,2,3 / 0,1,6,7,8 / 0,1,6,9 / 0,1,4,5; `retired`=5 after 21 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `pc_wr`=1 with pc_src=1 in the first BRANCH; `pc_wr`=0 in the second; 3 cycles each.
- jal → JAL cycle shows `reg_wr`=1, reg_dst=2, mem_to_reg=2, `pc_wr`=1, pc_src=2. Then jr → `pc_wr`=1, pc_src=3.
- Illegal op 3Fh, and op 0 with funct 00h → 2-cycle NOP, `retired` increments, and no reg/mem write occurs.
- `reset` asserted during MEM_RD of lw → `reg_wr` never asserts, `state`=0 and `retired`=0 on the next edge.
